// File: rtl/keccak_output_unit.sv
// ---------------------------------------------------------------------------
// keccak_pkg + keccak_output_unit
//
// Squeeze-phase output formatter of the Keccak engine. It selects a 256-bit
// output window from the 1600-bit permutation state, starting at the current
// squeeze byte offset. It also produces the byte-keep mask and the end-of-digest
// flag. It tells the control FSM when the current rate block has been used up,
// so that another permutation must be run.
//
// Build option:
//   KECCAK_OUTPUT_REG_EN  defined   -> every output is registered on the rising
//                                      edge of clk (1-cycle latency). rst
//                                      synchronously clears all outputs.
//                         undefined -> purely combinational (0 latency). clk
//                                      and rst are unused.
//
// Ports:
//   clk                    in   clock (used only in the registered build)
//   rst                    in   synchronous active-high reset (registered build)
//   state_array_i          in   [x][y][64] permutation state, lanes little-endian
//   keccak_mode_i          in   SHA3_224/256/384/512, SHAKE128/256; any other
//                               encoding is treated as SHAKE
//   rate_i                 in   rate in bits
//   bytes_squeezed_i       in   byte offset already squeezed in the rate block
//   bytes_squeezed_o       out  offset after this beat (0 when the block is spent)
//   squeeze_perm_needed_o  out  this beat exhausts the rate block
//   data_o                 out  256-bit output window, not masked by keep
//   keep_o                 out  per-byte valid mask, low bits first
//   last_o                 out  this beat completes a fixed-length SHA3 digest
// ---------------------------------------------------------------------------

package keccak_pkg;

  localparam int ROW_SIZE          = 5;
  localparam int COL_SIZE          = 5;
  localparam int LANE_SIZE         = 64;
  localparam int MODE_SEL_WIDTH    = 3;
  localparam int RATE_WIDTH        = 11;
  localparam int BYTE_ABSORB_WIDTH = 8;
  localparam int MAX_OUTPUT_DWIDTH = 256;

  localparam int STATE_BYTES = ROW_SIZE * COL_SIZE * LANE_SIZE / 8;

  localparam logic [MODE_SEL_WIDTH-1:0] SHA3_224 = 3'd0;
  localparam logic [MODE_SEL_WIDTH-1:0] SHA3_256 = 3'd1;
  localparam logic [MODE_SEL_WIDTH-1:0] SHA3_384 = 3'd2;
  localparam logic [MODE_SEL_WIDTH-1:0] SHA3_512 = 3'd3;
  localparam logic [MODE_SEL_WIDTH-1:0] SHAKE128 = 3'd4;
  localparam logic [MODE_SEL_WIDTH-1:0] SHAKE256 = 3'd5;

endpackage

module keccak_output_unit
  import keccak_pkg::*;
(
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0]   state_array_i,
  input  logic [MODE_SEL_WIDTH-1:0]                          keccak_mode_i,
  input  logic [RATE_WIDTH-1:0]                              rate_i,
  input  logic [BYTE_ABSORB_WIDTH-1:0]                       bytes_squeezed_i,
  output logic [BYTE_ABSORB_WIDTH-1:0]                       bytes_squeezed_o,
  output logic                                               squeeze_perm_needed_o,
  output logic [MAX_OUTPUT_DWIDTH-1:0]                       data_o,
  output logic [MAX_OUTPUT_DWIDTH/8-1:0]                     keep_o,
  output logic                                               last_o
);

  // One extra bit keeps off + valid and off + j from wrapping.
  localparam int OW         = BYTE_ABSORB_WIDTH + 1;
  localparam int OUT_BYTES  = MAX_OUTPUT_DWIDTH / 8;
  localparam int LANE_BYTES = LANE_SIZE / 8;
  localparam int IDX_SPAN   = 1 << BYTE_ABSORB_WIDTH;

  // -------------------------------------------------------------------------
  // Linear byte view of the state: byte 8*(5y+x)+k = lane[x][y] byte k.
  // The view is padded with zero up to the full offset range. A window that
  // runs past the end of the state then reads zeros, with no separate mux.
  // -------------------------------------------------------------------------
  logic [7:0] state_bytes [IDX_SPAN];

  for (genvar gy = 0; gy < COL_SIZE; gy++) begin : g_row
    for (genvar gx = 0; gx < ROW_SIZE; gx++) begin : g_col
      for (genvar gk = 0; gk < LANE_BYTES; gk++) begin : g_byte
        assign state_bytes[LANE_BYTES*(ROW_SIZE*gy+gx)+gk] =
          state_array_i[gx][gy][8*gk +: 8];
      end
    end
  end

  for (genvar gp = STATE_BYTES; gp < IDX_SPAN; gp++) begin : g_pad
    assign state_bytes[gp] = 8'h00;
  end

  // -------------------------------------------------------------------------
  // Offset arithmetic
  // -------------------------------------------------------------------------
  logic [OW-1:0] off_w;
  logic [OW-1:0] rate_bytes_w;
  logic [OW-1:0] rate_rem_w;
  logic [OW-1:0] dig_w;
  logic [OW-1:0] valid_w;
  logic [OW-1:0] end_w;
  logic          is_sha3_w;

  assign off_w        = OW'(bytes_squeezed_i);
  assign rate_bytes_w = OW'(rate_i[RATE_WIDTH-1:3]);
  assign rate_rem_w   = (off_w < rate_bytes_w) ? (rate_bytes_w - off_w) : '0;

  // The bits of rate_i below a whole byte do not affect the byte rate.
  logic unused_rate_lsb;
  assign unused_rate_lsb = ^rate_i[2:0];

  // SHAKE and unknown encodings have no digest length. In those modes dig_w
  // is never used, because is_sha3_w gates both the clip and last.
  always_comb begin
    is_sha3_w = 1'b1;
    dig_w     = '0;
    unique case (keccak_mode_i)
      SHA3_224: dig_w = OW'(28);
      SHA3_256: dig_w = OW'(32);
      SHA3_384: dig_w = OW'(48);
      SHA3_512: dig_w = OW'(64);
      default:  is_sha3_w = 1'b0;
    endcase
  end

  // valid = min(32, rate_rem [, dig - off while the digest is unfinished]).
  // If off >= rate_bytes, rate_rem is already 0, so valid is 0.
  always_comb begin
    valid_w = OW'(OUT_BYTES);
    if (rate_rem_w < valid_w) begin
      valid_w = rate_rem_w;
    end
    if (is_sha3_w && (off_w < dig_w) && ((dig_w - off_w) < valid_w)) begin
      valid_w = dig_w - off_w;
    end
  end

  assign end_w = off_w + valid_w;

  // -------------------------------------------------------------------------
  // Next output values
  // -------------------------------------------------------------------------
  logic [MAX_OUTPUT_DWIDTH-1:0]   data_d;
  logic [OUT_BYTES-1:0]           keep_d;
  logic                           last_d;
  logic                           perm_d;
  logic [BYTE_ABSORB_WIDTH-1:0]   bsq_d;

  always_comb begin
    data_d = '0;
    for (int j = 0; j < OUT_BYTES; j++) begin
      logic [OW-1:0] idx;
      idx = off_w + OW'(j);
      // Indices past the padded view can only come from the carry bit. They
      // lie beyond the state, so they stay zero.
      if (idx < OW'(STATE_BYTES)) begin
        data_d[8*j +: 8] = state_bytes[idx[BYTE_ABSORB_WIDTH-1:0]];
      end
    end
  end

  always_comb begin
    keep_d = '0;
    for (int j = 0; j < OUT_BYTES; j++) begin
      keep_d[j] = (OW'(j) < valid_w);
    end
  end

  assign perm_d = (end_w >= rate_bytes_w);
  assign last_d = is_sha3_w && (end_w >= dig_w);
  // end_w is at most max(rate_bytes, off), so it fits the counter width
  // whenever the block is not yet spent.
  assign bsq_d  = perm_d ? '0 : end_w[BYTE_ABSORB_WIDTH-1:0];

  // -------------------------------------------------------------------------
  // Output stage
  // -------------------------------------------------------------------------
`ifdef KECCAK_OUTPUT_REG_EN

  logic [MAX_OUTPUT_DWIDTH-1:0]   data_q;
  logic [OUT_BYTES-1:0]           keep_q;
  logic                           last_q;
  logic                           perm_q;
  logic [BYTE_ABSORB_WIDTH-1:0]   bsq_q;

  // When reset and a new input arrive in the same cycle, reset takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      keep_q <= '0;
      last_q <= 1'b0;
      perm_q <= 1'b0;
      bsq_q  <= '0;
    end else begin
      data_q <= data_d;
      keep_q <= keep_d;
      last_q <= last_d;
      perm_q <= perm_d;
      bsq_q  <= bsq_d;
    end
  end

  assign data_o                = data_q;
  assign keep_o                = keep_q;
  assign last_o                = last_q;
  assign squeeze_perm_needed_o = perm_q;
  assign bytes_squeezed_o      = bsq_q;

`else

  assign data_o                = data_d;
  assign keep_o                = keep_d;
  assign last_o                = last_d;
  assign squeeze_perm_needed_o = perm_d;
  assign bytes_squeezed_o      = bsq_d;

  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

`endif

endmodule

// File: tb/tb_keccak_output_unit.sv
module tb_keccak_output_unit;
  import keccak_pkg::*;

`ifdef KECCAK_OUTPUT_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [4:0][4:0][63:0]   state_array_i = '0;
  logic [2:0]              keccak_mode_i = '0;
  logic [10:0]             rate_i = '0;
  logic [7:0]              bytes_squeezed_i = '0;
  logic [7:0]              bytes_squeezed_o;
  logic                    squeeze_perm_needed_o;
  logic [255:0]            data_o;
  logic [31:0]             keep_o;
  logic                    last_o;

  always #5 clk = ~clk;

  keccak_output_unit dut (
    .clk                   (clk),
    .rst                   (rst),
    .state_array_i         (state_array_i),
    .keccak_mode_i         (keccak_mode_i),
    .rate_i                (rate_i),
    .bytes_squeezed_i      (bytes_squeezed_i),
    .bytes_squeezed_o      (bytes_squeezed_o),
    .squeeze_perm_needed_o (squeeze_perm_needed_o),
    .data_o                (data_o),
    .keep_o                (keep_o),
    .last_o                (last_o)
  );

  typedef struct {
    logic [255:0] data;
    logic [31:0]  keep;
    logic         last;
    logic         perm;
    logic [7:0]   bsq;
    int           due;
    string        tag;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  byte unsigned st[200];

  always @(posedge clk) cyc <= cyc + 1;

  // Rates in bits for the six defined modes, in encoding order.
  int rate_tab[6] = '{1152, 1088, 832, 576, 1344, 1088};

  function automatic exp_t model(int mode, int rate, int off);
    exp_t e;
    int rb, rem, dig, valid, b;
    bit sha3;
    rb   = rate / 8;
    rem  = (off < rb) ? rb - off : 0;
    sha3 = (mode >= 0 && mode <= 3);
    case (mode)
      0: dig = 28;
      1: dig = 32;
      2: dig = 48;
      3: dig = 64;
      default: dig = 0;
    endcase
    valid = (rem < 32) ? rem : 32;
    if (sha3 && off < dig && (dig - off) < valid) valid = dig - off;
    e.keep = '0;
    for (int j = 0; j < valid; j++) e.keep[j] = 1'b1;
    e.perm = (off + valid >= rb);
    e.bsq  = e.perm ? 8'd0 : 8'(off + valid);
    e.last = sha3 && (off + valid >= dig);
    e.data = '0;
    for (int j = 0; j < 32; j++) begin
      b = off + j;
      e.data[8*j +: 8] = (b < 200) ? st[b] : 8'h00;
    end
    e.due = 0;
    e.tag = "";
    return e;
  endfunction

  task automatic load_state();
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        for (int k = 0; k < 8; k++)
          state_array_i[x][y][8*k +: 8] = st[8*(5*y+x)+k];
  endtask

  task automatic fill_linear();
    for (int b = 0; b < 200; b++) st[b] = 8'(b);
  endtask

  task automatic fill_random();
    for (int b = 0; b < 200; b++) st[b] = 8'($urandom_range(0, 255));
  endtask

  task automatic issue(int mode, int rate, int off, bit r, string tag);
    exp_t e;
    @(posedge clk);
    #1;
    keccak_mode_i    = 3'(mode);
    rate_i           = 11'(rate);
    bytes_squeezed_i = 8'(off);
    rst              = r;
    load_state();
    e = model(mode, rate, off);
    if (r && LAT == 1) begin
      e.data = '0; e.keep = '0; e.last = 1'b0; e.perm = 1'b0; e.bsq = '0;
    end
    e.due = cyc + LAT;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic chk(string name, string tag, logic [255:0] act, logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h want %h", tag, name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.due < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s.timing: sampled at cycle %0d want %0d", e.tag, cyc, e.due);
      end else begin
        chk("data", e.tag, data_o, e.data);
        chk("keep", e.tag, 256'(keep_o), 256'(e.keep));
        chk("last", e.tag, 256'(last_o), 256'(e.last));
        chk("perm", e.tag, 256'(squeeze_perm_needed_o), 256'(e.perm));
        chk("bsq",  e.tag, 256'(bytes_squeezed_o), 256'(e.bsq));
      end
    end
  end

  initial begin
    int mode, rate, off, rb;
    fill_linear();
    issue(1, 1088, 0, 1'b1, "reset");
    issue(1, 1088, 0, 1'b0, "sha3_256_off0");
    issue(3, 576, 0, 1'b0, "sha3_512_off0");
    issue(3, 576, 32, 1'b0, "sha3_512_off32");
    issue(3, 576, 64, 1'b0, "sha3_512_off64");
    issue(4, 1344, 0, 1'b0, "shake128_off0");
    issue(4, 1344, 160, 1'b0, "shake128_off160");
    issue(3, 576, 32, 1'b1, "reset_mid");
    issue(0, 1152, 0, 1'b0, "sha3_224_off0");
    issue(5, 1088, 128, 1'b0, "shake256_off128");
    issue(2, 832, 200, 1'b0, "sha3_384_beyond");
    issue(6, 1088, 20, 1'b0, "unknown_mode");
    issue(4, 1344, 180, 1'b0, "window_past_state");

    for (int i = 0; i < 300; i++) begin
      fill_random();
      mode = $urandom_range(0, 7);
      rate = (mode < 6) ? rate_tab[mode] : rate_tab[$urandom_range(0, 5)];
      rb   = rate / 8;
      if ($urandom_range(0, 1) == 1) off = $urandom_range(0, 255);
      else begin
        off = rb - 40 + $urandom_range(0, 48);
        if (off > 255) off = 255;
      end
      issue(mode, rate, off, ($urandom_range(0, 15) == 0), "rand");
    end

    for (int t = 0; t < 10 && sb.size() > 0; t++) @(posedge clk);
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected beats never sampled, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
